// File: rtl/hex7seg_scan_ctrl_if.sv
// Purpose : load handshake and display outputs of the 7-segment scan controller.
// Latency : n/a (signal bundle only).
// Backpressure: load_ready low holds off the value source until the next frame boundary.
//
// Signals:
//   load, load_data, dp_in     value source -> controller (valid + payload)
//   load_ready                 controller -> source
//   an, a_to_g, dp, frame_tick controller -> display / observers
interface hex7seg_scan_ctrl_if #(
    parameter int NDIG = 4
);
    logic                load;
    logic [4*NDIG-1:0]   load_data;
    logic                load_ready;
    logic [NDIG-1:0]     dp_in;
    logic [NDIG-1:0]     an;
    logic [6:0]          a_to_g;
    logic                dp;
    logic                frame_tick;

    modport master (
        output load, load_data, dp_in,
        input  load_ready, an, a_to_g, dp, frame_tick
    );

    modport slave (
        input  load, load_data, dp_in,
        output load_ready, an, a_to_g, dp, frame_tick
    );
endinterface

// File: rtl/hex7seg_scan_ctrl.sv
// Purpose : time-multiplexed hex scan of an NDIG-digit common-anode 7-segment display.
// Latency : all outputs registered, one cycle behind the scan state.
// Backpressure: one value can be pending; load_ready stays low until it commits at a frame boundary.
//
// Ports:
//   clk  rising-edge clock
//   clr  synchronous active-high reset
//   bus  slave side of hex7seg_scan_ctrl_if (load/load_data/dp_in in,
//        load_ready/an/a_to_g/dp/frame_tick out)
// Optional build macro: HEX7SEG_LZ_SUPPRESS_EN blanks leading zero digits (digit 0 always shown).
module hex7seg_scan_ctrl #(
    parameter int NDIG = 4,
    parameter int DIV  = 50000,
    parameter int GAP  = 8
) (
    input  logic               clk,
    input  logic               clr,
    hex7seg_scan_ctrl_if.slave bus
);
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CMAX = (DIV > GAP) ? DIV : GAP;
    localparam int CW   = $clog2(CMAX);

    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    typedef enum logic {
        S_SHOW = 1'b0,
        S_GAP  = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [IW-1:0]     idx, idx_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              wrap;

    logic [4*NDIG-1:0] disp, shadow;
    logic [NDIG-1:0]   dp_reg, dp_shadow;
    logic              ready_q;

    logic [NDIG-1:0]   an_n, an_q;
    logic [6:0]        seg_n, seg_q;
    logic              dp_n, dp_q, tick_q;

    logic [3:0]        nib [NDIG];

    function automatic logic [6:0] hex_font(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    always_comb begin
        for (int k = 0; k < NDIG; k++) begin
            nib[k] = disp[4*k +: 4];
        end
    end

`ifdef HEX7SEG_LZ_SUPPRESS_EN
    // lz[k] is set when nibbles NDIG-1..k are all zero; lz[0] stays clear.
    logic [NDIG-1:0] lz;
    always_comb begin : lz_scan
        logic run;
        lz  = '0;
        run = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            run   = run & (nib[k] == 4'h0);
            lz[k] = run;
        end
    end
`endif

    // Scan state register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_SHOW;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    // Next scan state plus the output values for the current slot.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt + CW'(1);
        wrap    = 1'b0;
        an_n    = '1;
        seg_n   = '0;
        dp_n    = 1'b0;

        case (state)
            S_SHOW: begin
                if (cnt == DIV_LAST) begin
                    cnt_n   = '0;
                    state_n = S_GAP;
                end
                an_n[idx] = 1'b0;
                seg_n     = hex_font(nib[idx]);
                dp_n      = dp_reg[idx];
`ifdef HEX7SEG_LZ_SUPPRESS_EN
                // Blanked digit keeps its slot time; its dp bit still shows.
                if (lz[idx]) begin
                    an_n  = '1;
                    seg_n = '0;
                end
`endif
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = S_SHOW;
                    if (idx == IDX_LAST) begin
                        idx_n = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end
            end
            default: begin
                state_n = S_SHOW;
                cnt_n   = '0;
            end
        endcase
    end

    // Handshake, shadow/display registers and registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            disp      <= '0;
            dp_reg    <= '0;
            shadow    <= '0;
            dp_shadow <= '0;
            ready_q   <= 1'b1;
            an_q      <= '1;
            seg_q     <= '0;
            dp_q      <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            an_q   <= an_n;
            seg_q  <= seg_n;
            dp_q   <= dp_n;
            tick_q <= wrap;

            // ready_q low means a value is pending; only such a value commits.
            if (wrap && !ready_q) begin
                disp   <= shadow;
                dp_reg <= dp_shadow;
            end

            // A transfer on the boundary edge itself finds nothing pending,
            // so it waits for the following boundary.
            if (bus.load && ready_q) begin
                shadow    <= bus.load_data;
                dp_shadow <= bus.dp_in;
                ready_q   <= 1'b0;
            end else if (wrap) begin
                ready_q   <= 1'b1;
            end
        end
    end

    assign bus.load_ready = ready_q;
    assign bus.an         = an_q;
    assign bus.a_to_g     = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_hex7seg_scan_ctrl.sv
// Purpose : self-checking bench for hex7seg_scan_ctrl (NDIG=4, DIV=4, GAP=2).
// Latency : scoreboard expects outputs one cycle after the scan state they reflect.
// Backpressure: source holds load while load_ready is low.
module tb_hex7seg_scan_ctrl;
    localparam int NDIG  = 4;
    localparam int DIV   = 4;
    localparam int GAP   = 2;
    localparam int SLOT  = DIV + GAP;
    localparam int FRAME = NDIG * SLOT;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    hex7seg_scan_ctrl_if #(.NDIG(NDIG)) bus();

    hex7seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GAP(GAP)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        int         frame;
        logic [15:0] val;
        logic [3:0]  dpv;
    } commit_t;

    commit_t     exp_q[$];
    int          k = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [15:0] cur_val = '0;
    logic [3:0]  cur_dp  = '0;

    // Output cycle count since the last reset edge.
    always @(posedge clk) begin
        if (clr) k <= 0;
        else     k <= k + 1;
    end

    function automatic logic [6:0] font(input logic [3:0] h);
        logic [6:0] t [16];
        t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        return t[h];
    endfunction

    // Scoreboard: pops committed values at frame starts, checks every output cycle.
    always @(negedge clk) begin : monitor
        int          off, slot;
        logic        lit;
        logic [3:0]  nib;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp, e_tick;
        commit_t     c;
        if (mon_en) begin
            e_an = 4'hF; e_seg = '0; e_dp = 1'b0; e_tick = 1'b0;
            if (k == 0) begin
                cur_val = '0;
                cur_dp  = '0;
            end else begin
                off = (k - 1) % FRAME;
                if (off == 0) begin
                    while (exp_q.size() > 0 && exp_q[0].frame <= (k - 1) / FRAME) begin
                        c = exp_q.pop_front();
                        cur_val = c.val;
                        cur_dp  = c.dpv;
                    end
                end
                slot   = off / SLOT;
                lit    = (off % SLOT) < DIV;
                e_tick = (k % FRAME) == 0;
                if (lit) begin
                    nib        = cur_val[slot*4 +: 4];
                    e_an[slot] = 1'b0;
                    e_seg      = font(nib);
                    e_dp       = cur_dp[slot];
`ifdef HEX7SEG_LZ_SUPPRESS_EN
                    if (slot > 0 && (cur_val >> (4 * slot)) == 16'h0) begin
                        e_an  = 4'hF;
                        e_seg = '0;
                    end
`endif
                end
            end
            checks++;
            if ({bus.an, bus.a_to_g, bus.dp, bus.frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
                errors++;
                $display("FAIL scan k=%0d: got an=%b seg=%b dp=%b tick=%b, want an=%b seg=%b dp=%b tick=%b",
                         k, bus.an, bus.a_to_g, bus.dp, bus.frame_tick, e_an, e_seg, e_dp, e_tick);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until k == target; an overshoot or stall is a failed comparison.
    task automatic run_to(input int target);
        int budget = 200;
        while (k != target && budget > 0) begin
            step(1);
            budget--;
        end
        checks++;
        if (k != target) begin
            errors++;
            $display("FAIL run_to: k=%0d, wanted %0d", k, target);
        end
    endtask

    task automatic test_reset();
        bus.load      = 1'b0;
        bus.load_data = '0;
        bus.dp_in     = '0;
        clr           = 1'b1;
        step(2);
        checks++;
        if ({bus.an, bus.a_to_g, bus.dp, bus.frame_tick, bus.load_ready} !== {4'hF, 7'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset: an=%b seg=%b dp=%b tick=%b rdy=%b, want 1111 0000000 0 0 1",
                     bus.an, bus.a_to_g, bus.dp, bus.frame_tick, bus.load_ready);
        end
        clr    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_idle_scan();
        int ticks = 0;
        int bad   = 0;
        int nrdy  = 0;
        for (int i = 0; i < 2 * FRAME + 1; i++) begin
            step(1);
            if (bus.frame_tick) begin
                ticks++;
                if (k % FRAME != 0) bad++;
            end
            if (!bus.load_ready) nrdy++;
            if (k == 1) begin
                checks++;
                if (bus.an !== 4'b1110 || bus.a_to_g !== 7'b1111110) begin
                    errors++;
                    $display("FAIL idle_first_digit: an=%b seg=%b, want 1110 1111110", bus.an, bus.a_to_g);
                end
            end
            if (k == 5) begin
                checks++;
                if (bus.an !== 4'b1111 || bus.a_to_g !== 7'b0) begin
                    errors++;
                    $display("FAIL idle_gap: an=%b seg=%b, want 1111 0000000", bus.an, bus.a_to_g);
                end
            end
        end
        checks++;
        if (ticks != 2 || bad != 0) begin
            errors++;
            $display("FAIL idle_ticks: count=%0d misplaced=%0d, want 2 and 0", ticks, bad);
        end
        checks++;
        if (nrdy != 0) begin
            errors++;
            $display("FAIL idle_ready: low for %0d cycles, want 0", nrdy);
        end
    endtask

    task automatic test_load_midframe();
        int n;
        run_to(58);
        bus.load      = 1'b1;
        bus.load_data = 16'h12AF;
        bus.dp_in     = 4'b0101;
        n = (k + 1) / FRAME + 1;
        exp_q.push_back('{n, 16'h12AF, 4'b0101});
        step(1);
        bus.load = 1'b0;
        checks++;
        if (bus.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_ready_drop: got %b, want 0", bus.load_ready);
        end
        run_to(n * FRAME - 1);
        checks++;
        if (bus.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_ready_before_boundary: got %b, want 0", bus.load_ready);
        end
        step(1);
        checks++;
        if (bus.load_ready !== 1'b1 || bus.frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_after_boundary: rdy=%b tick=%b, want 1 1", bus.load_ready, bus.frame_tick);
        end
        run_to(n * FRAME + 1);
        checks++;
        if (bus.a_to_g !== 7'b1000111) begin
            errors++;
            $display("FAIL load_digit0_F: seg=%b, want 1000111", bus.a_to_g);
        end
        run_to(n * FRAME + 1 + SLOT);
        checks++;
        if (bus.a_to_g !== 7'b1110111) begin
            errors++;
            $display("FAIL load_digit1_A: seg=%b, want 1110111", bus.a_to_g);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int budget = 100;
        run_to(101);
        bus.load      = 1'b1;
        bus.load_data = 16'h1111;
        bus.dp_in     = 4'b0000;
        n = (k + 1) / FRAME + 1;
        exp_q.push_back('{n, 16'h1111, 4'b0000});
        step(1);
        bus.load_data = 16'h2222;
        bus.dp_in     = 4'b1111;
        checks++;
        if (bus.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy: rdy=%b, want 0", bus.load_ready);
        end
        while (!bus.load_ready && budget > 0) begin
            step(1);
            budget--;
        end
        checks++;
        if (k != n * FRAME) begin
            errors++;
            $display("FAIL b2b_ready_return: k=%0d, want %0d", k, n * FRAME);
        end
        exp_q.push_back('{(k + 1) / FRAME + 1, 16'h2222, 4'b1111});
        step(1);
        bus.load = 1'b0;
        checks++;
        if (bus.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: rdy=%b, want 0", bus.load_ready);
        end
    endtask

    task automatic test_coincident();
        int budget = 200;
        while (!(k % FRAME == FRAME - 1 && bus.load_ready) && budget > 0) begin
            step(1);
            budget--;
        end
        checks++;
        if (k != 167) begin
            errors++;
            $display("FAIL coinc_align: k=%0d, want 167", k);
        end
        bus.load      = 1'b1;
        bus.load_data = 16'h3456;
        bus.dp_in     = 4'b0010;
        exp_q.push_back('{(k + 1) / FRAME + 1, 16'h3456, 4'b0010});
        step(1);
        bus.load = 1'b0;
        checks++;
        if (bus.load_ready !== 1'b0 || bus.frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL coinc_capture: rdy=%b tick=%b, want 0 1", bus.load_ready, bus.frame_tick);
        end
        run_to(192);
        checks++;
        if (bus.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL coinc_commit_ready: rdy=%b, want 1", bus.load_ready);
        end
    endtask

    task automatic test_clr_midframe();
        run_to(195);
        bus.load      = 1'b1;
        bus.load_data = 16'hABCD;
        bus.dp_in     = 4'b1001;
        exp_q.push_back('{(k + 1) / FRAME + 1, 16'hABCD, 4'b1001});
        run_to(199);
        checks++;
        if (bus.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_pending: rdy=%b, want 0", bus.load_ready);
        end
        // Load stays high through the clear: the clear must win.
        clr = 1'b1;
        exp_q.delete();
        step(1);
        clr      = 1'b0;
        bus.load = 1'b0;
        checks++;
        if (bus.an !== 4'hF || bus.a_to_g !== 7'h00 || bus.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_outputs: an=%b seg=%b rdy=%b, want 1111 0000000 1",
                     bus.an, bus.a_to_g, bus.load_ready);
        end
        step(1);
        checks++;
        if (bus.an !== 4'b1110 || bus.a_to_g !== 7'b1111110) begin
            errors++;
            $display("FAIL clr_restart: an=%b seg=%b, want 1110 1111110", bus.an, bus.a_to_g);
        end
        run_to(2 * FRAME + 1);
    endtask

`ifdef HEX7SEG_LZ_SUPPRESS_EN
    task automatic test_lz();
        int n;
        bus.load      = 1'b1;
        bus.load_data = 16'h0050;
        bus.dp_in     = 4'b0000;
        n = (k + 1) / FRAME + 1;
        exp_q.push_back('{n, 16'h0050, 4'b0000});
        step(1);
        bus.load = 1'b0;
        run_to(n * FRAME + 1 + SLOT);
        checks++;
        if (bus.an !== 4'b1101 || bus.a_to_g !== 7'b1011011) begin
            errors++;
            $display("FAIL lz_digit1: an=%b seg=%b, want 1101 1011011", bus.an, bus.a_to_g);
        end
        run_to(n * FRAME + 1 + 3 * SLOT);
        checks++;
        if (bus.an !== 4'b1111 || bus.a_to_g !== 7'b0) begin
            errors++;
            $display("FAIL lz_digit3: an=%b seg=%b, want 1111 0000000", bus.an, bus.a_to_g);
        end
        run_to((n + 1) * FRAME + 1);
    endtask
`endif

    initial begin
        test_reset();
        test_idle_scan();
        test_load_midframe();
        test_back_to_back();
        test_coincident();
        test_clr_midframe();
`ifdef HEX7SEG_LZ_SUPPRESS_EN
        test_lz();
`endif
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex7seg_scan_ctrl.md
Name: hex7seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Holds an NDIG-digit hex value and cycles through the digits one at a time. For each digit it decodes the nibble to a_to_g and drives that digit's anode.
- Inserts an all-anodes-off gap between digits to prevent ghosting.
- Accepts new display values through a valid/ready handshake and commits them only at frame boundaries, so no frame ever shows a mix of old and new values.

Parameters:
- NDIG, 4, number of digits (2..8).
- DIV, 50000, clock cycles each digit is lit (>=2).
- GAP, 8, blank cycles between digits (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  synchronous active-high reset.
- load  input  1  new-value valid.
- load_data  input  4*NDIG  hex value; nibble k feeds digit k, digit 0 is the least significant.
- load_ready  output  1  controller can accept a value.
- dp_in  input  NDIG  decimal-point enables, sampled with load_data.
- an  output  NDIG  digit anodes, active low.
- a_to_g  output  7  segments, active high; bit6 = a … bit0 = g.
- dp  output  1  decimal point, active high.
- frame_tick  output  1  one-cycle pulse when the digit index wraps to 0.

Behaviour:
- Reset (clr=1 at a clock edge):
  - State S_SHOW, digit index 0, prescale counter 0.
  - Display register 0, dp register 0, no value pending.
  - Outputs: an = all ones, a_to_g = 0, dp = 0, load_ready = 1, frame_tick = 0.
  - clr overrides load in the same cycle; a pending value is discarded.
- All outputs are registered. They reflect the state and index of the previous cycle (1-cycle latency).
- Decode: the standard hex font, 0–F, active-high segments.
  - 0 → 7'b1111110, 1 → 7'b0110000, 8 → 7'b1111111, A → 7'b1110111, F → 7'b1000111.
- FSM:
  - S_SHOW:
    - an[idx] = 0, all other an bits 1.
    - a_to_g = decode(nibble idx), dp = dp register bit idx.
    - Counter increments; at DIV-1 it clears and the FSM moves to S_GAP.
  - S_GAP:
    - an = all ones, a_to_g = 0, dp = 0.
    - Counter increments; at GAP-1 it clears, idx advances (NDIG-1 wraps to 0), and the FSM returns to S_SHOW.
- Frame boundary = the S_GAP→S_SHOW transition where idx wraps from NDIG-1 to 0.
  - frame_tick pulses on the first cycle of the new frame.
- Load handshake:
  - Transfer occurs when load & load_ready. load_data and dp_in are captured into a shadow register and a pending flag is set.
  - load_ready = ~pending.
  - At a frame boundary, if pending: shadow → display register and pending clears. load_ready is 1 again the following cycle.
  - Load asserted while load_ready=0 is ignored; the source must hold it.
  - A transfer in the same cycle as a frame boundary is not committed at that boundary. It commits at the next boundary.
- The displayed value never changes mid-frame.

Optional Feature:
- Macro: HEX7SEG_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression. For digit k > 0, if nibbles NDIG-1..k of the display register are all 0, the digit is blanked:
  - a_to_g = 0 and an stays high for that slot.
  - The dp bit still drives dp.
  - Digit 0 is never suppressed.
  - Scan timing is unchanged.
- Undefined: all digits always shown; no extra logic.

Test Plan (NDIG=4, DIV=4, GAP=2):
- Reset then idle, value 0 → an sequence 1110 ×4 cycles, 1111 ×2, 1101 ×4, 1111 ×2, …. a_to_g = 7'b1111110 during lit cycles. frame_tick every 24 cycles.
- Load 16'h12AF mid-frame → load_ready drops the next cycle. Current frame still shows 0000. The next frame shows F, A, 2, 1 on digits 0..3. load_ready returns 1 one cycle after the boundary.
- Back-to-back: load 16'h1111, then a second load while load_ready=0 → the second load is ignored. Only 1111 is displayed; after re-presenting, the second value appears one frame later.
- Load coincident with a frame boundary → committed at the following boundary, not the coincident one.
- clr asserted mid-S_SHOW with a value pending → next cycle an = 1111, a_to_g = 0, load_ready = 1. Display restarts at digit 0 showing 0.
- With HEX7SEG_LZ_SUPPRESS_EN defined, value 16'h0050 → digits 3 and 2 blank (an stays 1111 in their slots). Digit 1 shows 5, digit 0 shows 0.
